// File: rtl/sprite_pkg.sv
// Shared encodings, screen defaults and packed-parameter helpers for the sprite animator.
package sprite_pkg;

  typedef enum logic [1:0] {
    MODE_LOOP           = 2'd0,
    MODE_ONESHOT_HOLD   = 2'd1,
    MODE_ONESHOT_RETURN = 2'd2
  } anim_mode_e;

  localparam int          SCR_W_DEF       = 96;
  localparam int          SCR_H_DEF       = 64;
  localparam logic [15:0] TRANSPARENT_DEF = 16'hFFFF;

  // Per-state field widths inside STATE_FRAMES / STATE_MODE; up to 32 states fit the helper.
  localparam int FRAMES_FW   = 8;
  localparam int MODE_FW     = 2;
  localparam int FIELD_VEC_W = 256;

  function automatic logic [7:0] state_field(input logic [FIELD_VEC_W-1:0] vec,
                                             input int unsigned idx,
                                             input int unsigned w);
    logic [FIELD_VEC_W-1:0] mask;
    mask = (FIELD_VEC_W'(1) << w) - FIELD_VEC_W'(1);
    return 8'((vec >> (idx * w)) & mask);
  endfunction

  // RGB565 tint: the 6-bit green field is halved, red and blue pass through.
  function automatic logic [15:0] halve_green(input logic [15:0] c);
    return {c[15:11], 1'b0, c[10:6], c[4:0]};
  endfunction

endpackage

// File: rtl/sprite_animator_seq.sv
// Animation sequencer: tick divider, per-state frame stepping, one-shot completion tracking.
module anim_sequencer
  import sprite_pkg::*;
#(
  parameter int                             FRAME_DIV    = 6_250_000,
  parameter int                             NUM_STATES   = 8,
  parameter int                             MAX_FRAMES   = 4,
  parameter logic [NUM_STATES*FRAMES_FW-1:0] STATE_FRAMES = {NUM_STATES{8'd4}},
  parameter logic [NUM_STATES*MODE_FW-1:0]   STATE_MODE   = '0,
  localparam int CSW   = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1,
  localparam int FW    = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [CSW-1:0] character_state,
  input  logic [1:0]     move_state,
  output logic [FW-1:0]  frame_sel,
  output logic           anim_done
);

  localparam int CNT_W = $clog2(FRAME_DIV);
  localparam logic [FIELD_VEC_W-1:0] FRAMES_EXT = FIELD_VEC_W'(STATE_FRAMES);
  localparam logic [FIELD_VEC_W-1:0] MODES_EXT  = FIELD_VEC_W'(STATE_MODE);

  logic [CNT_W-1:0] tick_cnt;
  logic [CSW-1:0]   prev_state;
  logic             done_hold;
  logic             state_change;
  logic             tick;
  logic [7:0]       last_frame;
  logic [7:0]       frame_ext;
  anim_mode_e       mode_cur;

  always_comb begin
    state_change = (character_state != prev_state);
    tick         = (tick_cnt == CNT_W'(FRAME_DIV - 1)) && !state_change;
    last_frame   = state_field(FRAMES_EXT, 32'(character_state), FRAMES_FW) - 8'd1;
    mode_cur     = anim_mode_e'(2'(state_field(MODES_EXT, 32'(character_state), MODE_FW)));
    frame_ext    = 8'(frame_sel);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt   <= '0;
      frame_sel  <= '0;
      done_hold  <= 1'b0;
      anim_done  <= 1'b0;
      // Tracking the live input avoids a spurious restart right after reset release.
      prev_state <= character_state;
    end else begin
      // NOTE: non-blocking default makes anim_done a single-clk pulse; later assignments win.
      anim_done  <= 1'b0;
      prev_state <= character_state;
      if (state_change) begin
        tick_cnt  <= '0;
        frame_sel <= '0;
        done_hold <= 1'b0;
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
        if (tick) begin
          if (character_state == '0) begin
            unique case (move_state)
              2'd1:    frame_sel <= (frame_sel == '0) ? FW'(1) : '0;
              2'd2:    frame_sel <= (frame_sel == '0) ? FW'(2) : '0;
              default: frame_sel <= '0;
            endcase
          end else begin
            unique case (mode_cur)
              MODE_ONESHOT_HOLD: begin
                if (!done_hold) begin
                  if (frame_ext >= last_frame) begin
                    anim_done <= 1'b1;
                    done_hold <= 1'b1;
                  end else begin
                    frame_sel <= frame_sel + FW'(1);
                    if (frame_ext + 8'd1 == last_frame) begin
                      anim_done <= 1'b1;
                      done_hold <= 1'b1;
                    end
                  end
                end
              end
              MODE_ONESHOT_RETURN: begin
                if (!done_hold) begin
                  if (frame_ext >= last_frame) begin
                    frame_sel <= '0;
                    anim_done <= 1'b1;
                    done_hold <= 1'b1;
                  end else begin
                    frame_sel <= frame_sel + FW'(1);
                  end
                end
              end
              default: frame_sel <= (frame_ext >= last_frame) ? '0 : frame_sel + FW'(1);
            endcase
          end
        end
      end
    end
  end

endmodule

// File: rtl/sprite_animator.sv
// Sprite animator top: frame sequencer plus a two-stage raster-to-ROM pixel pipeline.
module sprite_animator
  import sprite_pkg::*;
#(
  parameter int                             FRAME_DIV    = 6_250_000,
  parameter int                             NUM_STATES   = 8,
  parameter int                             MAX_FRAMES   = 4,
  parameter logic [NUM_STATES*FRAMES_FW-1:0] STATE_FRAMES = {NUM_STATES{8'd4}},
  parameter logic [NUM_STATES*MODE_FW-1:0]   STATE_MODE   = '0,
  parameter int                             SCR_W        = SCR_W_DEF,
  parameter int                             SCR_H        = SCR_H_DEF,
  parameter logic [15:0]                    TRANSPARENT  = TRANSPARENT_DEF,
  localparam int CSW = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1,
  localparam int FW  = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [12:0]    pixel_index,
  input  logic [6:0]     x,
  input  logic [6:0]     y,
  input  logic           mirror,
  input  logic           modify_col,
  input  logic [CSW-1:0] character_state,
  input  logic [1:0]     move_state,
  output logic [12:0]    rom_addr,
  output logic [FW-1:0]  frame_sel,
  input  logic [15:0]    rom_colour,
  output logic [15:0]    oled_colour,
  output logic           anim_done
);

  localparam logic signed [8:0] HALF_W = 9'(SCR_W / 2);
  localparam logic signed [8:0] HALF_H = 9'(SCR_H / 2);
  localparam logic signed [8:0] W_S    = 9'(SCR_W);
  localparam logic signed [8:0] H_S    = 9'(SCR_H);

  logic [FW-1:0] cur_frame;

  anim_sequencer #(
    .FRAME_DIV   (FRAME_DIV),
    .NUM_STATES  (NUM_STATES),
    .MAX_FRAMES  (MAX_FRAMES),
    .STATE_FRAMES(STATE_FRAMES),
    .STATE_MODE  (STATE_MODE)
  ) u_seq (
    .clk            (clk),
    .rst_n          (rst_n),
    .character_state(character_state),
    .move_state     (move_state),
    .frame_sel      (cur_frame),
    .anim_done      (anim_done)
  );

  logic [6:0]        px, py;
  logic signed [8:0] px_s, py_s, x_s, y_s, col, row;
  logic              oob_d, oob_q;
  logic [12:0]       addr_d;

  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    px     = 7'(pixel_index % 13'(SCR_W));
    py     = 7'(pixel_index / 13'(SCR_W));
    px_s   = $signed({2'b00, px});
    py_s   = $signed({2'b00, py});
    x_s    = $signed({2'b00, x});
    y_s    = $signed({2'b00, y});
    col    = mirror ? (HALF_W + x_s - px_s) : (px_s - x_s + HALF_W);
    row    = py_s - y_s + HALF_H;
    oob_d  = (col < 0) || (col >= W_S) || (row < 0) || (row >= H_S);
    addr_d = oob_d ? '0 : 13'(int'(row) * SCR_W + int'(col));
  end

  // Stage 1: frame_sel travels with rom_addr so one pixel never mixes two frames.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_addr  <= '0;
      oob_q     <= 1'b1;
      frame_sel <= '0;
    end else begin
      rom_addr  <= addr_d;
      oob_q     <= oob_d;
      frame_sel <= cur_frame;
    end
  end

  // Stage 2: background never receives the tint.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oled_colour <= TRANSPARENT;
    end else if (oob_q) begin
      oled_colour <= TRANSPARENT;
    end else if (modify_col && (rom_colour != TRANSPARENT)) begin
      oled_colour <= halve_green(rom_colour);
    end else begin
      oled_colour <= rom_colour;
    end
  end

endmodule

// File: doc/sprite_animator.md
SPRITE_ANIMATOR -- requirements
Module: sprite_animator

Interface
REQ-001 Parameter FRAME_DIV, 6_250_000, clk cycles per animation tick (8 Hz at 50 MHz); minimum 2.
REQ-002 Parameter NUM_STATES, 8, number of character states; character_state width is clog2(NUM_STATES), minimum 1.
REQ-003 Parameter MAX_FRAMES, 4, maximum frames per state; frame_sel width is clog2(MAX_FRAMES).
REQ-004 Parameter STATE_FRAMES, packed vector, frame count per state, each 1..MAX_FRAMES.
REQ-005 Parameter STATE_MODE, packed 2 bits per state: 0 = LOOP, 1 = ONESHOT_HOLD, 2 = ONESHOT_RETURN (ends on frame 0).
REQ-006 Parameter SCR_W, 96, and SCR_H, 64, screen and sprite dimensions in pixels.
REQ-007 Parameter TRANSPARENT, 16'hFFFF, background colour; it is never tinted.
REQ-008 clk  in  1  system clock; the only clock.
REQ-009 rst_n  in  1  reset, synchronous, active-low.
REQ-010 pixel_index  in  13  raster index, 0..SCR_W*SCR_H-1.
REQ-011 x, y  in  7 each  sprite centre on screen.
REQ-012 mirror  in  1  horizontal flip; modify_col  in  1  green-halving tint.
REQ-013 character_state  in  clog2(NUM_STATES)  animation selector.
REQ-014 move_state  in  2  0 idle, 1 forward, 2 backward; used only in state 0.
REQ-015 rom_addr  out  13  sprite-local pixel index sent to the frame ROMs.
REQ-016 frame_sel  out  clog2(MAX_FRAMES)  current frame number.
REQ-017 rom_colour  in  16  ROM data for (frame_sel, rom_addr), combinational in the same cycle.
REQ-018 oled_colour  out  16  final pixel colour.
REQ-019 anim_done  out  1  one-clk pulse when a one-shot animation completes.

Function
REQ-020 Tick counter counts 0..FRAME_DIV-1, wraps, and asserts tick for one clk at FRAME_DIV-1.
REQ-021 A change of character_state in any cycle resets frame_sel to 0, clears done_hold, and restarts the tick counter on that clk.
REQ-022 In state 0 on tick: move 0 gives frame 0; move 1 toggles 0/1; move 2 toggles 0/2; move 3 gives frame 0.
REQ-023 LOOP mode (states other than 0) on tick: frame_sel advances and wraps to 0 after STATE_FRAMES-1.
REQ-024 ONESHOT_HOLD on tick: frame_sel advances to STATE_FRAMES-1 and holds there. The tick that reaches the last frame pulses anim_done.
REQ-025 ONESHOT_RETURN on tick: frame_sel advances; the tick after the last frame sets frame_sel to 0, pulses anim_done and sets done_hold. While done_hold is set, frame_sel stays 0.
REQ-026 A state with STATE_FRAMES = 1 keeps frame_sel at 0. A one-shot state with STATE_FRAMES = 1 pulses anim_done on its first tick, once.
REQ-027 Stage 1 (registered): px = pixel_index mod SCR_W, py = pixel_index div SCR_W.
REQ-028 Stage 1, column: col = px - x + SCR_W/2 when not mirrored; col = SCR_W/2 + x - px when mirrored.
REQ-029 Stage 1, row: row = py - y + SCR_H/2.
REQ-030 Use signed 9-bit arithmetic for col and row. If col is outside 0..SCR_W-1 or row is outside 0..SCR_H-1, register oob = 1 and rom_addr = 0. There is no wrap-around.
REQ-031 Otherwise rom_addr = row*SCR_W + col, registered.
REQ-032 Stage 2 (registered): oled_colour = TRANSPARENT if oob, else rom_colour.
REQ-033 In stage 2, if modify_col = 1 and the colour is not TRANSPARENT, bits [10:5] shift right by 1; other bits are unchanged.
REQ-034 Latency from pixel_index to oled_colour is exactly 2 clk at full throughput.
REQ-035 frame_sel is sampled in stage 1 and pipelined alongside the pixel, so a frame change cannot split one pixel between frames.

Reset
REQ-036 While rst_n = 0 at a clk edge: tick counter = 0, frame_sel = 0, done_hold = 0, anim_done = 0, rom_addr = 0, oob = 1, oled_colour = TRANSPARENT.
REQ-037 Reset mid-animation abandons the sequence. The first tick after release advances from frame 0.

Structure
REQ-038 Package sprite_pkg holds the mode encodings, TRANSPARENT, SCR_W/SCR_H defaults, and a function that extracts per-state fields from the packed parameters.
REQ-039 Sub-module anim_sequencer contains the tick counter, frame_sel, done_hold and anim_done. The top level holds the two-stage pixel pipeline.

Verification (FRAME_DIV = 4, STATE_FRAMES = {3,3,3}, modes {0: LOOP, 1: ONESHOT_RETURN, 2: ONESHOT_HOLD})
REQ-040 State 0, move 1, 8 ticks -> frame_sel 1,0,1,0,...; switch to move 2 -> 2,0,2,0; no anim_done pulses.
REQ-041 State 1 for 5 ticks -> frame_sel 1, 2, 0 with anim_done on the third tick, then held at 0.
REQ-042 State 2 -> frame_sel 1, 2, 2, ... with one anim_done pulse. Changing state at tick 1 restarts at 0 with no pulse.
REQ-043 x = 48, y = 32, mirror = 0, pixel_index = 100 -> rom_addr 100 after 1 clk. With mirror = 1 -> rom_addr = 96 + 92 = 188.
REQ-044 x = 10, pixel_index = 95 (col = 133) -> oled_colour = 16'hFFFF after 2 clk regardless of rom_colour.
REQ-045 modify_col = 1, rom_colour = 16'h07E0 -> 16'h03E0; rom_colour = 16'hFFFF -> 16'hFFFF.
REQ-046 rst_n = 0 for 1 clk during the state-1 animation -> all outputs at reset values next clk; the sequence restarts from frame 0.
